uart_reg_bridge: RTL

Parametrised UART-to-register-bus bridge, the successor to the fixed ahbuart link used in the out-of-context designs. It receives framed 8N1 commands on a serial line, performs single read or write transactions on a generic req/ack register bus of configurable address and data width, and returns a serial response. It includes an inter-byte timeout and framing-error recovery, so a host can resynchronise without a reset.

---
 rtl/uart_reg_bridge.sv | 374 +++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: UART (8N1) command interface to a single req/ack register bus.
//
// A host sends commands over the serial line. The bridge runs one bus
// transaction per command and answers over the serial output.
//   write : 0x01, addr bytes, data bytes (MSB-first)  -> reply 0x06
//   read  : 0x02, addr bytes (MSB-first)              -> reply rdata bytes (MSB-first)
//   other command byte                                -> reply 0x15
// An inter-byte timeout and stop-bit checking let the host resynchronise
// without a reset.
//
// Ports:
//   clk        single clock
//   reset      asynchronous, active-high reset
//   uarti      serial input (idle high, asynchronous to clk)
//   uarto      serial output (idle high)
//   bus_req    transaction request, held until bus_ack
//   bus_we     1 = write, 0 = read; valid with bus_req
//   bus_addr   transaction address
//   bus_wdata  write data
//   bus_ack    one-cycle transaction completion
//   bus_rdata  read data, captured on bus_ack
//   frame_err  one-cycle pulse when a received stop bit is 0
module uart_reg_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT_CYC  = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uarti,
  output logic              uarto,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              frame_err
);

  localparam int ADDR_B = ADDR_W / 8;
  localparam int DATA_B = DATA_W / 8;
  localparam int MAX_B  = (ADDR_B > DATA_B) ? ADDR_B : DATA_B;
  localparam int BCNT_W = $clog2(MAX_B + 1);
  localparam int BIT_CW = $clog2(CLKS_PER_BIT);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BIT_CW-1:0] BIT_LAST  = BIT_CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CW-1:0] HALF_LAST = BIT_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCNT_W-1:0] ADDR_LAST = BCNT_W'(ADDR_B - 1);
  localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_B - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam logic [7:0] RSP_OK = 8'h06;
  localparam logic [7:0] RSP_NG = 8'h15;

  typedef enum logic [2:0] {RX_WAIT, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_BUS, P_RESP} p_state_t;

  // ---------------------------------------------------------------- RX
  logic              sync1_q, sync2_q;
  rx_state_t         rx_state_q, rx_state_d;
  logic [BIT_CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_sh_q, rx_sh_d;
  logic              frame_err_q, frame_err_d;
  logic              rx_done_s, rx_ferr_s;

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uarti;
      sync2_q <= sync1_q;
    end
  end

  // Receiver sequencing: start check at half bit, then 8 data bits and stop.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    frame_err_d = 1'b0;
    rx_done_s   = 1'b0;
    rx_ferr_s   = 1'b0;
    case (rx_state_q)
      // After reset or a bad frame, a start is only accepted once the line has been high.
      RX_WAIT: begin
        if (sync2_q) rx_state_d = RX_IDLE;
        else         rx_state_d = RX_WAIT;
      end
      RX_IDLE: begin
        if (!sync2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          if (sync2_q) rx_state_d = RX_IDLE;   // glitch
          else         rx_state_d = RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (sync2_q) begin
            rx_done_s  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_s   = 1'b1;
            frame_err_d = 1'b1;
            rx_state_d  = RX_WAIT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_WAIT;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q  <= RX_WAIT;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_sh_q     <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------- TX
  logic              tx_busy_q, tx_busy_d;
  logic [BIT_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]        tx_bit_q, tx_bit_d;
  logic [8:0]        tx_sh_q, tx_sh_d;
  logic              uarto_q, uarto_d;
  logic              tx_start_s;
  logic [7:0]        tx_byte_s;
  logic              tx_done_s;

  // Last cycle of the stop bit; a new byte started here follows with no gap.
  assign tx_done_s = tx_busy_q && (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);

  // Transmitter: bit 0 is start, 1..8 data, 9 stop; tx_sh holds {stop, data}.
  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    uarto_d   = uarto_q;
    if (tx_start_s) begin
      tx_busy_d = 1'b1;
      tx_cnt_d  = '0;
      tx_bit_d  = 4'd0;
      tx_sh_d   = {1'b1, tx_byte_s};
      uarto_d   = 1'b0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          uarto_d   = 1'b1;
        end else begin
          uarto_d  = tx_sh_q[0];
          tx_sh_d  = {1'b1, tx_sh_q[8:1]};
          tx_bit_d = tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end else begin
      uarto_d = 1'b1;
    end
  end

  // Transmitter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= 4'd0;
      tx_sh_q   <= 9'h1FF;
      uarto_q   <= 1'b1;
    end else begin
      tx_busy_q <= tx_busy_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      uarto_q   <= uarto_d;
    end
  end

  // ------------------------------------------------------------ parser
  p_state_t          p_state_q, p_state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] resp_sh_q, resp_sh_d;
  logic [BCNT_W-1:0] resp_left_q, resp_left_d;

  // Command parser, bus handshake and response sequencing.
  always_comb begin
    p_state_d   = p_state_q;
    bcnt_d      = bcnt_q;
    to_d        = to_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    resp_sh_d   = resp_sh_q;
    resp_left_d = resp_left_q;
    tx_start_s  = 1'b0;
    tx_byte_s   = 8'h00;
    case (p_state_q)
      P_IDLE: begin
        if (rx_done_s) begin
          if ((rx_sh_q == CMD_WR) || (rx_sh_q == CMD_RD)) begin
            p_state_d = P_ADDR;
            bus_we_d  = (rx_sh_q == CMD_WR);
            bcnt_d    = '0;
            to_d      = '0;
          end else begin
            p_state_d   = P_RESP;
            tx_start_s  = 1'b1;
            tx_byte_s   = RSP_NG;
            resp_left_d = '0;
          end
        end else begin
          p_state_d = P_IDLE;
        end
      end
      P_ADDR: begin
        if (rx_ferr_s) begin
          p_state_d = P_IDLE;
        end else if (rx_done_s) begin
          to_d       = '0;
          bus_addr_d = ADDR_W'({bus_addr_q, rx_sh_q});
          if (bcnt_q == ADDR_LAST) begin
            bcnt_d = '0;
            if (bus_we_q) begin
              p_state_d = P_DATA;
            end else begin
              p_state_d = P_BUS;
              bus_req_d = 1'b1;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else if (to_q == TO_LAST) begin
          p_state_d = P_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      P_DATA: begin
        if (rx_ferr_s) begin
          p_state_d = P_IDLE;
        end else if (rx_done_s) begin
          to_d        = '0;
          bus_wdata_d = DATA_W'({bus_wdata_q, rx_sh_q});
          if (bcnt_q == DATA_LAST) begin
            p_state_d = P_BUS;
            bus_req_d = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else if (to_q == TO_LAST) begin
          p_state_d = P_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      P_BUS: begin
        if (bus_ack && bus_req_q) begin
          bus_req_d  = 1'b0;
          p_state_d  = P_RESP;
          tx_start_s = 1'b1;
          if (bus_we_q) begin
            tx_byte_s   = RSP_OK;
            resp_left_d = '0;
          end else begin
            tx_byte_s   = bus_rdata[DATA_W-1 -: 8];
            resp_sh_d   = DATA_W'({bus_rdata, 8'h00});
            resp_left_d = DATA_LAST;
          end
        end else begin
          p_state_d = P_BUS;
        end
      end
      P_RESP: begin
        if (tx_done_s) begin
          if (resp_left_q == '0) begin
            p_state_d = P_IDLE;
          end else begin
            tx_start_s  = 1'b1;
            tx_byte_s   = resp_sh_q[DATA_W-1 -: 8];
            resp_sh_d   = DATA_W'({resp_sh_q, 8'h00});
            resp_left_d = resp_left_q - 1'b1;
          end
        end else begin
          p_state_d = P_RESP;
        end
      end
      default: p_state_d = P_IDLE;
    endcase
  end

  // Parser and bus output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_state_q   <= P_IDLE;
      bcnt_q      <= '0;
      to_q        <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      resp_sh_q   <= '0;
      resp_left_q <= '0;
    end else begin
      p_state_q   <= p_state_d;
      bcnt_q      <= bcnt_d;
      to_q        <= to_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      resp_sh_q   <= resp_sh_d;
      resp_left_q <= resp_left_d;
    end
  end

  assign uarto     = uarto_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign frame_err = frame_err_q;

endmodule
